// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Contents: FSM state enum, bus widths, and the address-to-word-index
// conversion that also reports alignment/range validity.
package mem_if_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic              ok;
    logic [ADDR_W-1:0] index;
  } addr_chk_t;

  // Word index relative to base; ok only for aligned, in-window addresses.
  function automatic addr_chk_t addr_to_index(input logic [ADDR_W-1:0] addr,
                                              input logic [ADDR_W-1:0] base,
                                              input logic [ADDR_W-1:0] depth);
    addr_chk_t r;
    r.index = (addr - base) >> 2;
    r.ok    = (addr[1:0] == 2'b00) && (addr >= base) && (r.index < depth);
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU memory stage and the data memory.
// master: requester (drives req_*, rsp_ready); slave: responder.
interface data_mem_responder_if;
  import mem_if_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_ram.sv
// dm_byte_ram: DEPTH_WORDS x 32 storage with per-byte write enables and a
// registered read port.
// Ports: clk, rst_n (clears read register only), i_we (byte lanes),
// i_re (load word), i_clr (zero read register), i_addr, i_wdata, o_rdata.
module dm_byte_ram
  import mem_if_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BE_W-1:0]   i_we,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Byte-lane writes; array contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // Read register doubles as the response data register; held when idle.
  always_ff @(posedge clk) begin
    if (!rst_n)     r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re)  r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory target with programmable
// wait states, byte-enable stores and an error response for bad addresses.
// Ports: clk, rst_n (sync, active-low), bus (slave side of
// data_mem_responder_if: request channel in, response channel out).
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_req_ready, w_req_ready_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;

  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [WORD_W-1:0]  r_wdata;
  logic [BE_W-1:0]    r_be;

  logic               w_accept;
  logic               w_rsp_hs;
  logic               w_exec;
  addr_chk_t          w_chk;
  logic [BE_W-1:0]    w_ram_we;
  logic               w_ram_re;
  logic               w_ram_clr;
  logic [WORD_W-1:0]  w_ram_rdata;
  logic               w_unused_idx;

  // r_req_ready is high exactly in IDLE, r_rsp_valid exactly in RESP.
  assign w_accept = r_req_ready & bus.req_valid;
  assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;
  assign w_exec   = (r_state == EXEC);
  assign w_chk    = addr_to_index(r_addr, BASE_ADDR, ADDR_W'(DEPTH_WORDS));
  assign w_unused_idx = ^w_chk.index[ADDR_W-1:IDX_W];

  // Gating with rst_n drops a store whose EXEC edge coincides with reset.
  assign w_ram_we  = (w_exec && r_we && w_chk.ok && rst_n) ? r_be : '0;
  assign w_ram_re  = w_exec && !r_we && w_chk.ok;
  assign w_ram_clr = w_exec && (r_we || !w_chk.ok);

  // Request payload captured only on the acceptance edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= bus.req_we;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_be    <= bus.req_be;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rsp_err_nxt = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
          w_state_nxt = (WAIT_CYCLES == 0) ? EXEC : WAIT;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = EXEC;
      end
      EXEC: begin
        w_rsp_err_nxt = !w_chk.ok;
        w_state_nxt   = RESP;
      end
      RESP: begin
        if (w_rsp_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_req_ready_nxt = (w_state_nxt == IDLE);
    w_rsp_valid_nxt = (w_state_nxt == RESP);
  end

  dm_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_clr   (w_ram_clr),
    .i_addr  (w_chk.index[IDX_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = w_ram_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
